ssp_tx_logic: RTL

- Transmit serializer for the SSP link; drives the frame-format serial pins that the peer receive logic samples on its SSPCLKIN rising edge.
- Pops bytes from the transmit FIFO and generates the SSP serial clock, a one-period frame-sync pulse and MSB-first data.
- Supports back-to-back frames.

---
 rtl/ssp_tx_logic.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ssp_tx_logic.sv
// ssp_tx_logic: SSP transmit serializer.
// Pops bytes from the transmit FIFO and drives SSPCLKOUT, a one-period
// frame-sync pulse and MSB-first data. Back-to-back frames run with no idle gap.
// Optional feature macro: SSP_TX_LOOPBACK_EN (adds LBM input and LB_* outputs).
module ssp_tx_logic #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       PCLK,
  input  logic       CLEAR,
  input  logic       SSE,
  input  logic       TxVALID,
  input  logic [7:0] TxDATA,
`ifdef SSP_TX_LOOPBACK_EN
  input  logic       LBM,
  output logic       LB_CLK,
  output logic       LB_FSS,
  output logic       LB_TXD,
`endif
  output logic       TxREAD,
  output logic       SSPCLKOUT,
  output logic       SSPFSSOUT,
  output logic       SSPTXD,
  output logic       SSPOE_B,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [7:0] HC_MAX = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] hc_q, hc_d;
  logic       sclk_q, sclk_d;
  logic       fss_q, fss_d;
  logic       txd_q, txd_d;
  logic       oe_b_q, oe_b_d;
  logic       busy_q, busy_d;
  logic       txread_q, txread_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic       b2b_q, b2b_d;

  logic       wrap_s;
  logic       fall_s;
  logic [7:0] hc_next_s;
  logic       load_ok_s;

  // Half-period timing: wrap ends a half period, a wrap while high is a fall.
  always_comb begin
    wrap_s    = (hc_q == HC_MAX);
    fall_s    = wrap_s && sclk_q;
    hc_next_s = wrap_s ? 8'd0 : (hc_q + 8'd1);
    load_ok_s = SSE && TxVALID;
  end

  // Next-state logic: frame sequencing, FIFO pops and serial pin values.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    sclk_d   = sclk_q;
    fss_d    = fss_q;
    txd_d    = txd_q;
    oe_b_d   = oe_b_q;
    busy_d   = busy_q;
    txread_d = 1'b0;
    shift_d  = shift_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    b2b_d    = b2b_q;
    case (state_q)
      ST_IDLE: begin
        hc_d   = 8'd0;
        sclk_d = 1'b0;
        fss_d  = 1'b0;
        txd_d  = 1'b0;
        oe_b_d = 1'b1;
        busy_d = 1'b0;
        idx_d  = 3'd7;
        b2b_d  = 1'b0;
        if (load_ok_s) begin
          txread_d = 1'b1;
          shift_d  = TxDATA;
          state_d  = ST_SYNC;
          fss_d    = 1'b1;
          oe_b_d   = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        hc_d = hc_next_s;
        if (wrap_s) begin
          sclk_d = ~sclk_q;
        end else begin
          sclk_d = sclk_q;
        end
        if (fall_s) begin
          fss_d   = 1'b0;
          txd_d   = shift_q[7];
          idx_d   = 3'd7;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SHIFT: begin
        hc_d = hc_next_s;
        if (wrap_s) begin
          sclk_d = ~sclk_q;
        end else begin
          sclk_d = sclk_q;
        end
        if (fall_s) begin
          if (idx_q == 3'd0) begin
            if (b2b_q) begin
              // Next byte follows immediately; its sync was sent with our LSB.
              shift_d = hold_q;
              txd_d   = hold_q[7];
              fss_d   = 1'b0;
              idx_d   = 3'd7;
              b2b_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              hc_d    = 8'd0;
              sclk_d  = 1'b0;
              fss_d   = 1'b0;
              txd_d   = 1'b0;
              oe_b_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q - 3'd1;
            txd_d = shift_q[idx_q - 3'd1];
            if ((idx_q == 3'd1) && load_ok_s) begin
              // Entering the LSB with data waiting: pop it and flag back-to-back.
              txread_d = 1'b1;
              hold_d   = TxDATA;
              fss_d    = 1'b1;
              b2b_d    = 1'b1;
            end else begin
              fss_d = 1'b0;
            end
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hc_d    = 8'd0;
        sclk_d  = 1'b0;
        fss_d   = 1'b0;
        txd_d   = 1'b0;
        oe_b_d  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = 3'd7;
        b2b_d   = 1'b0;
      end
    endcase
  end

  // State and core output registers with synchronous clear.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q  <= ST_IDLE;
      hc_q     <= 8'd0;
      sclk_q   <= 1'b0;
      fss_q    <= 1'b0;
      txd_q    <= 1'b0;
      oe_b_q   <= 1'b1;
      busy_q   <= 1'b0;
      txread_q <= 1'b0;
      shift_q  <= 8'd0;
      hold_q   <= 8'd0;
      idx_q    <= 3'd7;
      b2b_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      sclk_q   <= sclk_d;
      fss_q    <= fss_d;
      txd_q    <= txd_d;
      oe_b_q   <= oe_b_d;
      busy_q   <= busy_d;
      txread_q <= txread_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      b2b_q    <= b2b_d;
    end
  end

  assign TxREAD = txread_q;
  assign BUSY   = busy_q;

`ifdef SSP_TX_LOOPBACK_EN
  logic pin_clk_q, pin_clk_d;
  logic pin_fss_q, pin_fss_d;
  logic pin_txd_q, pin_txd_d;
  logic pin_oe_b_q, pin_oe_b_d;
  logic lb_clk_q, lb_clk_d;
  logic lb_fss_q, lb_fss_d;
  logic lb_txd_q, lb_txd_d;

  // Route the serial signals either to the pads or to the loopback outputs.
  always_comb begin
    if (LBM) begin
      pin_clk_d  = 1'b0;
      pin_fss_d  = 1'b0;
      pin_txd_d  = 1'b0;
      pin_oe_b_d = 1'b1;
      lb_clk_d   = sclk_d;
      lb_fss_d   = fss_d;
      lb_txd_d   = txd_d;
    end else begin
      pin_clk_d  = sclk_d;
      pin_fss_d  = fss_d;
      pin_txd_d  = txd_d;
      pin_oe_b_d = oe_b_d;
      lb_clk_d   = 1'b0;
      lb_fss_d   = 1'b0;
      lb_txd_d   = 1'b0;
    end
  end

  // Pad and loopback output registers.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      pin_clk_q  <= 1'b0;
      pin_fss_q  <= 1'b0;
      pin_txd_q  <= 1'b0;
      pin_oe_b_q <= 1'b1;
      lb_clk_q   <= 1'b0;
      lb_fss_q   <= 1'b0;
      lb_txd_q   <= 1'b0;
    end else begin
      pin_clk_q  <= pin_clk_d;
      pin_fss_q  <= pin_fss_d;
      pin_txd_q  <= pin_txd_d;
      pin_oe_b_q <= pin_oe_b_d;
      lb_clk_q   <= lb_clk_d;
      lb_fss_q   <= lb_fss_d;
      lb_txd_q   <= lb_txd_d;
    end
  end

  assign SSPCLKOUT = pin_clk_q;
  assign SSPFSSOUT = pin_fss_q;
  assign SSPTXD    = pin_txd_q;
  assign SSPOE_B   = pin_oe_b_q;
  assign LB_CLK    = lb_clk_q;
  assign LB_FSS    = lb_fss_q;
  assign LB_TXD    = lb_txd_q;
`else
  assign SSPCLKOUT = sclk_q;
  assign SSPFSSOUT = fss_q;
  assign SSPTXD    = txd_q;
  assign SSPOE_B   = oe_b_q;
`endif

endmodule
